nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
Multi-precision adder sequencer. It adds two WIDTH-bit operands 4 bits per cycle using one instance of the existing 4-bit ripple-carry adder par_4bit_add, and registers the carry between nibbles. It sits between a requester (start/done handshake) and the shared 4-bit add slice, trading latency for area on wide additions.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; N = WIDTH/4 nibbles.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle (busy=0)
a  input  WIDTH  operand A; sampled with accepted start
b  input  WIDTH  operand B; sampled with accepted start
cin  input  1  carry-in; sampled with accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result
cout  output  1  registered final carry-out

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0. Internal carry, nibble index, operand registers and accumulator all 0.
- States:
  - IDLE: start=1 latches a, b and cin into operand registers, sets carry register=cin and index=0, and goes to RUN. busy=1 from the next cycle.
  - RUN: each cycle feeds nibble[index] of A and B plus the carry register to the slice. The slice sum is written into accumulator nibble[index], the slice cout goes into the carry register, and index increments.
  - Last nibble (index=N-1): the accumulator with the final nibble is copied into sum, the slice cout goes to cout, done=1 for one cycle, busy=0, and the state returns to IDLE.
- Latency: if start is sampled at edge E, done is high during the cycle after edge E+N; busy is high for exactly N cycles.
- Output stability: sum and cout change only on the edge that raises done. They hold the previous result during RUN and after done.
- start while busy=1 is ignored; the in-flight operation is unaffected and no request is queued.
- start high during the done cycle is accepted, since the state is already IDLE. The minimum issue period is N+1 cycles.
- Input stability: operand inputs may change freely after the accept edge.
- Arithmetic: result = (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum. Carry wraps across all nibble boundaries exactly as in a WIDTH-bit ripple adder.
- Reset mid-operation: aborts immediately. All outputs return to reset values, no done pulse is produced, and the next start behaves as from a fresh reset.
- rst and start high together: reset wins.
- WIDTH=4 (N=1): done comes one cycle after acceptance.

Optional Feature:
Macro: NIBBLE_SERIAL_ADDSUB_EN
- Defined: adds input port sub (1 bit), sampled with accepted start.
  - sub=1: every B nibble is inverted before the slice and the initial carry is forced to 1 (cin ignored), giving sum = a - b mod 2^WIDTH.
  - Subtraction carry: cout=1 means no borrow (a>=b); cout=0 means borrow.
  - sub=0: identical to plain add.
- Not defined: port sub is absent; block only adds; no inversion logic is synthesized.

Test Plan:
1. WIDTH=16, reset, then start with a=16'h1234, b=16'h1111, cin=0 -> busy high 4 cycles, done pulses 4 cycles after acceptance, sum=16'h2345, cout=0.
2. Full carry ripple:
   - a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1.
   - a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1.
   - a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1.
3. Start while busy: accept a=16'h0001, b=16'h0001, then pulse start with a=16'hAAAA, b=16'h5555 at cycle 2 -> single done, sum=16'h0002; no second done within 6 cycles.
4. Reset mid-operation: assert rst 2 cycles after accepting a=16'h1234, b=16'h4321 -> busy=0, done never pulses, sum=0, cout=0. A new start with a=16'h0F0F, b=16'h00F1 -> sum=16'h1000, cout=0.
5. Back-to-back: hold start high with operands 1+2, then 3+4 presented after the first accept -> done pulses 5 cycles apart, sum=16'h0003 then 16'h0007. sum holds 16'h0003 between pulses.
6. With NIBBLE_SERIAL_ADDSUB_EN:
   - sub=1, a=16'h0005, b=16'h0007, cin=1 -> sum=16'hFFFE, cout=0.
   - sub=1, a=16'h0007, b=16'h0005 -> sum=16'h0002, cout=1.
   - sub=0 repeats scenario 1 results.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: multi-precision adder sequencer.
// Adds two WIDTH-bit operands one nibble per cycle through a single shared
// 4-bit ripple-carry slice (par_4bit_add), carrying between nibbles in a
// register. WIDTH must be a multiple of 4 and at least 4.
// Optional feature macro: NIBBLE_SERIAL_ADDSUB_EN adds a 'sub' input that
// turns the operation into a - b (B inverted, initial carry forced to 1).

// 4-bit ripple-carry add slice shared by the sequencer.
module par_4bit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] c;

   // Ripple the carry through four full-adder bits.
   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = c[4];

endmodule

module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
`ifdef NIBBLE_SERIAL_ADDSUB_EN
   input  logic             sub,
`endif
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N     = WIDTH / 4;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef NIBBLE_SERIAL_ADDSUB_EN
   logic             sub_q, sub_d;
`endif

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       slice_sum;
   logic             slice_cout;

   // Select the current nibble of each operand for the shared slice.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == i[IDX_W-1:0]) begin
            nib_a = a_q[i*4 +: 4];
            nib_b = b_q[i*4 +: 4];
         end
      end
`ifdef NIBBLE_SERIAL_ADDSUB_EN
      // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
      nib_b = nib_b ^ {4{sub_q}};
`endif
   end

   par_4bit_add u_slice (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Next-state logic: accept a request in IDLE, walk the nibbles in RUN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_EN
      sub_d   = sub_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
`ifdef NIBBLE_SERIAL_ADDSUB_EN
               sub_d   = sub;
               if (sub) begin
                  carry_d = 1'b1;
               end
`endif
            end
         end
         S_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == i[IDX_W-1:0]) begin
                  acc_d[i*4 +: 4] = slice_sum;
               end
            end
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            // Final nibble: publish the result and return to IDLE.
            if (idx_q == LAST_IDX) begin
               sum_d   = acc_d;
               cout_d  = slice_cout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               idx_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDSUB_EN
         sub_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef NIBBLE_SERIAL_ADDSUB_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
